rc4_key_search_ctrl: RTL and testbench

Top-level sequencer for the RC4 brute-force decoder. For each candidate key it runs the init, shuffle and decrypt FSMs in order, then checks the decrypt verdict and either stops or moves to the next key. It also owns the single-port S-memory: only the FSM of the active phase drives address, data and write enable.

---
 rtl/rc4_key_search_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_rc4_key_search_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_key_search_ctrl.sv
// RC4 brute-force key search sequencer: runs init, shuffle and decrypt for each
// candidate key and gives the single-port S-memory to whichever phase is active.
module rc4_key_search_ctrl #(
  parameter int unsigned          KEY_WIDTH = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_START = 24'h000000,
  parameter logic [KEY_WIDTH-1:0] KEY_END   = 24'h3FFFFF,
  parameter int unsigned          AW        = 8,
  parameter int unsigned          DW        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  input  logic                 abort,
  output logic                 init_start,
  input  logic                 init_complete,
  output logic                 shuf_start,
  input  logic                 shuf_complete,
  output logic                 dec_start,
  input  logic                 dec_complete,
  input  logic                 dec_valid,
  output logic                 sub_stop,
  input  logic [AW-1:0]        init_addr,
  input  logic [DW-1:0]        init_data,
  input  logic                 init_wren,
  input  logic [AW-1:0]        shuf_addr,
  input  logic [DW-1:0]        shuf_data,
  input  logic                 shuf_wren,
  input  logic [AW-1:0]        dec_addr,
  input  logic [DW-1:0]        dec_data,
  input  logic                 dec_wren,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_data,
  output logic                 mem_wren,
  output logic [KEY_WIDTH-1:0] secret_key,
  output logic [KEY_WIDTH-1:0] attempt_count,
  output logic                 busy,
  output logic                 key_found,
  output logic                 key_exhausted
);

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StInit      = 3'd1;
  localparam logic [2:0] StShuffle   = 3'd2;
  localparam logic [2:0] StDecrypt   = 3'd3;
  localparam logic [2:0] StCheck     = 3'd4;
  localparam logic [2:0] StNextKey   = 3'd5;
  localparam logic [2:0] StFound     = 3'd6;
  localparam logic [2:0] StExhausted = 3'd7;

  logic [2:0]           state_q, state_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [KEY_WIDTH-1:0] count_q, count_d;
  logic                 valid_q, valid_d;
  logic                 found_q, found_d;
  logic                 exhausted_q, exhausted_d;
  logic                 init_start_q, init_start_d;
  logic                 shuf_start_q, shuf_start_d;
  logic                 dec_start_q, dec_start_d;
  logic                 sub_stop_q, sub_stop_d;
  logic                 busy_q, busy_d;
  logic                 busy_now;

  assign busy_now = (state_q == StInit) || (state_q == StShuffle) || (state_q == StDecrypt) ||
                    (state_q == StCheck) || (state_q == StNextKey);

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    count_d     = count_q;
    valid_d     = valid_q;
    found_d     = found_q;
    exhausted_d = exhausted_q;
    sub_stop_d  = 1'b0;

    if (abort) begin
      // Abort beats go; sub-FSMs only need a stop when one was actually running.
      state_d    = StIdle;
      sub_stop_d = busy_now;
    end else begin
      case (state_q)
        StIdle, StFound, StExhausted: begin
          if (go) begin
            state_d     = StInit;
            key_d       = KEY_START;
            count_d     = '0;
            found_d     = 1'b0;
            exhausted_d = 1'b0;
          end
        end
        // A start pulse marks the first cycle of a phase, where a stale done level is ignored.
        StInit: begin
          if (!init_start_q && init_complete) state_d = StShuffle;
        end
        StShuffle: begin
          if (!shuf_start_q && shuf_complete) state_d = StDecrypt;
        end
        StDecrypt: begin
          if (!dec_start_q && dec_complete) begin
            state_d = StCheck;
            valid_d = dec_valid;
          end
        end
        StCheck: begin
          count_d = count_q + 1'b1;
          if (valid_q) begin
            state_d = StFound;
            found_d = 1'b1;
          end else begin
            state_d    = StNextKey;
            sub_stop_d = 1'b1;
          end
        end
        StNextKey: begin
          if (key_q == KEY_END) begin
            state_d     = StExhausted;
            exhausted_d = 1'b1;
          end else begin
            state_d = StInit;
            key_d   = key_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    init_start_d = (state_d == StInit) && (state_q != StInit);
    shuf_start_d = (state_d == StShuffle) && (state_q != StShuffle);
    dec_start_d  = (state_d == StDecrypt) && (state_q != StDecrypt);
    busy_d       = (state_d == StInit) || (state_d == StShuffle) || (state_d == StDecrypt) ||
                   (state_d == StCheck) || (state_d == StNextKey);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      key_q        <= KEY_START;
      count_q      <= '0;
      valid_q      <= 1'b0;
      found_q      <= 1'b0;
      exhausted_q  <= 1'b0;
      init_start_q <= 1'b0;
      shuf_start_q <= 1'b0;
      dec_start_q  <= 1'b0;
      sub_stop_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      found_q      <= found_d;
      exhausted_q  <= exhausted_d;
      init_start_q <= init_start_d;
      shuf_start_q <= shuf_start_d;
      dec_start_q  <= dec_start_d;
      sub_stop_q   <= sub_stop_d;
      busy_q       <= busy_d;
    end
  end

  // Memory ownership follows the registered state only, so non-owners never reach the RAM.
  always_comb begin
    mem_addr = '0;
    mem_data = '0;
    mem_wren = 1'b0;
    case (state_q)
      StInit: begin
        mem_addr = init_addr;
        mem_data = init_data;
        mem_wren = init_wren;
      end
      StShuffle: begin
        mem_addr = shuf_addr;
        mem_data = shuf_data;
        mem_wren = shuf_wren;
      end
      StDecrypt: begin
        mem_addr = dec_addr;
        mem_data = dec_data;
        mem_wren = dec_wren;
      end
      default: ;
    endcase
  end

  assign init_start    = init_start_q;
  assign shuf_start    = shuf_start_q;
  assign dec_start     = dec_start_q;
  assign sub_stop      = sub_stop_q;
  assign secret_key    = key_q;
  assign attempt_count = count_q;
  assign busy          = busy_q;
  assign key_found     = found_q;
  assign key_exhausted = exhausted_q;

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Bench for rc4_key_search_ctrl: two instances (full key range and KEY_END=3), timed
// sub-FSM stand-ins, a phase-level reference model compared every cycle, and directed checks.
module tb_rc4_key_search_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        go [2];
  logic        abort [2];
  logic        init_start [2], shuf_start [2], dec_start [2], sub_stop [2];
  logic        init_complete [2], shuf_complete [2], dec_complete [2], dec_valid [2];
  logic [7:0]  init_addr, init_data, shuf_addr, shuf_data, dec_addr, dec_data;
  logic        init_wren, shuf_wren, dec_wren;
  logic [7:0]  mem_addr [2], mem_data [2];
  logic        mem_wren [2];
  logic [23:0] secret_key [2], attempt_count [2];
  logic        busy [2], key_found [2], key_exhausted [2];

  int total = 0;
  int bad = 0;
  int vmode = 0;  // 0: every key passes, 1: only key 5 passes, 2: none pass
  int cyc = 0;
  bit pat_fixed = 0;
  bit started = 0;

  rc4_key_search_ctrl #(.KEY_WIDTH(24), .KEY_START(24'h000000), .KEY_END(24'h3FFFFF),
                        .AW(8), .DW(8)) dut0 (
    .clk(clk), .reset(reset), .go(go[0]), .abort(abort[0]),
    .init_start(init_start[0]), .init_complete(init_complete[0]),
    .shuf_start(shuf_start[0]), .shuf_complete(shuf_complete[0]),
    .dec_start(dec_start[0]), .dec_complete(dec_complete[0]), .dec_valid(dec_valid[0]),
    .sub_stop(sub_stop[0]),
    .init_addr(init_addr), .init_data(init_data), .init_wren(init_wren),
    .shuf_addr(shuf_addr), .shuf_data(shuf_data), .shuf_wren(shuf_wren),
    .dec_addr(dec_addr), .dec_data(dec_data), .dec_wren(dec_wren),
    .mem_addr(mem_addr[0]), .mem_data(mem_data[0]), .mem_wren(mem_wren[0]),
    .secret_key(secret_key[0]), .attempt_count(attempt_count[0]), .busy(busy[0]),
    .key_found(key_found[0]), .key_exhausted(key_exhausted[0])
  );

  rc4_key_search_ctrl #(.KEY_WIDTH(24), .KEY_START(24'h000000), .KEY_END(24'h000003),
                        .AW(8), .DW(8)) dut1 (
    .clk(clk), .reset(reset), .go(go[1]), .abort(abort[1]),
    .init_start(init_start[1]), .init_complete(init_complete[1]),
    .shuf_start(shuf_start[1]), .shuf_complete(shuf_complete[1]),
    .dec_start(dec_start[1]), .dec_complete(dec_complete[1]), .dec_valid(dec_valid[1]),
    .sub_stop(sub_stop[1]),
    .init_addr(init_addr), .init_data(init_data), .init_wren(init_wren),
    .shuf_addr(shuf_addr), .shuf_data(shuf_data), .shuf_wren(shuf_wren),
    .dec_addr(dec_addr), .dec_data(dec_data), .dec_wren(dec_wren),
    .mem_addr(mem_addr[1]), .mem_data(mem_data[1]), .mem_wren(mem_wren[1]),
    .secret_key(secret_key[1]), .attempt_count(attempt_count[1]), .busy(busy[1]),
    .key_found(key_found[1]), .key_exhausted(key_exhausted[1])
  );

  // Sub-FSM stand-ins: done level rises LAT cycles after start and stays until the next start.
  int  sm_cnt [2][3];
  logic sm_done [2][3];
  int  lat [3] = '{10, 30, 20};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int s = 0; s < 3; s++) begin
        logic st;
        st = (s == 0) ? init_start[i] : (s == 1) ? shuf_start[i] : dec_start[i];
        if (reset) begin
          sm_cnt[i][s] <= 0;
          sm_done[i][s] <= 1'b0;
        end else if (st) begin
          sm_cnt[i][s] <= lat[s];
          sm_done[i][s] <= 1'b0;
        end else if (sm_cnt[i][s] > 1) begin
          sm_cnt[i][s] <= sm_cnt[i][s] - 1;
        end else if (sm_cnt[i][s] == 1) begin
          sm_cnt[i][s] <= 0;
          sm_done[i][s] <= 1'b1;
        end
      end
    end
  end

  assign init_complete[0] = sm_done[0][0];
  assign shuf_complete[0] = sm_done[0][1];
  assign dec_complete[0]  = sm_done[0][2];
  assign init_complete[1] = sm_done[1][0];
  assign shuf_complete[1] = sm_done[1][1];
  assign dec_complete[1]  = sm_done[1][2];
  assign dec_valid[0] = (vmode == 0) || (vmode == 1 && secret_key[0] == 24'd5);
  assign dec_valid[1] = (vmode == 0) || (vmode == 1 && secret_key[1] == 24'd5);

  // Every sub-FSM issues a changing memory request every cycle, owner or not.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!pat_fixed) begin
      init_addr = cyc[7:0];
      init_data = cyc[7:0] ^ 8'h5A;
      init_wren = cyc[0];
      shuf_addr = cyc[7:0] + 8'h40;
      shuf_data = ~cyc[7:0];
      shuf_wren = cyc[1];
      dec_addr  = cyc[7:0] + 8'h80;
      dec_data  = cyc[7:0] + 8'h33;
      dec_wren  = cyc[0] ^ cyc[2];
    end
  end

  // Reference model. Phases: 0 idle, 1 init, 2 shuffle, 3 decrypt, 4 check, 5 next key,
  // 6 found, 7 exhausted. m_first marks the first cycle spent in phases 1..3.
  int          m_ph [2];
  bit          m_first [2], m_stop [2], m_found [2], m_exh [2], m_vq [2];
  logic [23:0] m_key [2], m_cnt [2];

  function automatic logic [23:0] kend(input int i);
    return (i == 0) ? 24'h3FFFFF : 24'h000003;
  endfunction

  function automatic bit ph_busy(input int p);
    return (p >= 1) && (p <= 5);
  endfunction

  always @(posedge clk) begin
    started = 1;
    for (int i = 0; i < 2; i++) begin
      int nxt;
      logic done;
      nxt = m_ph[i];
      m_stop[i] = 0;
      if (reset) begin
        nxt = 0;
        m_ph[i] = 0;
        m_key[i] = 24'h0;
        m_cnt[i] = 24'h0;
        m_found[i] = 0;
        m_exh[i] = 0;
        m_vq[i] = 0;
      end else if (abort[i]) begin
        m_stop[i] = ph_busy(m_ph[i]);
        nxt = 0;
      end else begin
        case (m_ph[i])
          0, 6, 7: if (go[i]) begin
            nxt = 1;
            m_key[i] = 24'h0;
            m_cnt[i] = 24'h0;
            m_found[i] = 0;
            m_exh[i] = 0;
          end
          1, 2, 3: begin
            done = (m_ph[i] == 1) ? init_complete[i] :
                   (m_ph[i] == 2) ? shuf_complete[i] : dec_complete[i];
            if (!m_first[i] && done) begin
              if (m_ph[i] == 3) m_vq[i] = dec_valid[i];
              nxt = m_ph[i] + 1;
            end
          end
          4: begin
            m_cnt[i] = m_cnt[i] + 24'd1;
            if (m_vq[i]) begin
              nxt = 6;
              m_found[i] = 1;
            end else begin
              nxt = 5;
            end
          end
          5: if (m_key[i] == kend(i)) begin
            nxt = 7;
            m_exh[i] = 1;
          end else begin
            m_key[i] = m_key[i] + 24'd1;
            nxt = 1;
          end
          default: nxt = 0;
        endcase
      end
      m_first[i] = (nxt >= 1) && (nxt <= 3) && (nxt != m_ph[i]);
      m_ph[i] = nxt;
    end
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] at %0t: got=%h want=%h", nm, i, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        logic [6:0]  exp_fl;
        logic [16:0] exp_mem;
        exp_fl = {m_first[i] && m_ph[i] == 1, m_first[i] && m_ph[i] == 2,
                  m_first[i] && m_ph[i] == 3, m_ph[i] == 5 || m_stop[i],
                  ph_busy(m_ph[i]), m_found[i], m_exh[i]};
        case (m_ph[i])
          1: exp_mem = {init_addr, init_data, init_wren};
          2: exp_mem = {shuf_addr, shuf_data, shuf_wren};
          3: exp_mem = {dec_addr, dec_data, dec_wren};
          default: exp_mem = 17'h0;
        endcase
        chk("flags", i, 32'({init_start[i], shuf_start[i], dec_start[i], sub_stop[i],
                             busy[i], key_found[i], key_exhausted[i]}), 32'(exp_fl));
        chk("key", i, 32'(secret_key[i]), 32'(m_key[i]));
        chk("count", i, 32'(attempt_count[i]), 32'(m_cnt[i]));
        chk("mem", i, 32'({mem_addr[i], mem_data[i], mem_wren[i]}), 32'(exp_mem));
      end
    end
  end

  // Pulse monitor for instance 0.
  int n_init, n_shuf, n_dec, n_stop, t_init, t_shuf, t_dec;
  always @(negedge clk) begin
    if (init_start[0]) begin n_init++; if (t_init < 0) t_init = cyc; end
    if (shuf_start[0]) begin n_shuf++; if (t_shuf < 0) t_shuf = cyc; end
    if (dec_start[0]) begin n_dec++; if (t_dec < 0) t_dec = cyc; end
    if (sub_stop[0]) n_stop++;
  end

  task automatic clear_mon();
    n_init = 0; n_shuf = 0; n_dec = 0; n_stop = 0;
    t_init = -1; t_shuf = -1; t_dec = -1;
  endtask

  task automatic pulse_go(input int i);
    @(posedge clk); #1 go[i] = 1'b1;
    @(posedge clk); #1 go[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget, input string nm);
    int n = 0;
    while (busy[i] && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk(nm, i, 32'(n), 32'(budget - 1));
  endtask

  task automatic wait_start(input int which, input int budget, input string nm);
    int n = 0;
    @(negedge clk);
    while (!((which == 1) ? shuf_start[0] : dec_start[0]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk(nm, 0, 32'(n), 32'(budget - 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset with random inputs
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      go[i] = 1'($urandom);
      abort[i] = 1'($urandom);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      go[i] = 1'($urandom);
      abort[i] = 1'($urandom);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      go[i] = 1'b0;
      abort[i] = 1'b0;
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_strobes", i, 32'({init_start[i], shuf_start[i], dec_start[i], sub_stop[i]}), 0);
      chk("rst_busy", i, 32'(busy[i]), 0);
      chk("rst_flags", i, 32'({key_found[i], key_exhausted[i]}), 0);
      chk("rst_key", i, 32'(secret_key[i]), 0);
      chk("rst_count", i, 32'(attempt_count[i]), 0);
      chk("rst_wren", i, 32'(mem_wren[i]), 0);
    end

    // 2. first key passes
    vmode = 0;
    clear_mon();
    pulse_go(0);
    wait_done(0, 500, "t2_timeout");
    chk("t2_init_pulses", 0, 32'(n_init), 1);
    chk("t2_shuf_pulses", 0, 32'(n_shuf), 1);
    chk("t2_dec_pulses", 0, 32'(n_dec), 1);
    chk("t2_order", 0, 32'(t_init >= 0 && t_init < t_shuf && t_shuf < t_dec), 1);
    chk("t2_key", 0, 32'(secret_key[0]), 0);
    chk("t2_count", 0, 32'(attempt_count[0]), 1);
    chk("t2_found", 0, 32'(key_found[0]), 1);
    chk("t2_busy", 0, 32'(busy[0]), 0);

    // 3. only key 5 passes; restart straight from FOUND
    vmode = 1;
    clear_mon();
    pulse_go(0);
    wait_done(0, 3000, "t3_timeout");
    chk("t3_key", 0, 32'(secret_key[0]), 5);
    chk("t3_count", 0, 32'(attempt_count[0]), 6);
    chk("t3_found", 0, 32'(key_found[0]), 1);
    chk("t3_sub_stops", 0, 32'(n_stop), 5);

    // 4. KEY_END=3, nothing passes
    vmode = 2;
    pulse_go(1);
    wait_done(1, 3000, "t4_timeout");
    chk("t4_key", 1, 32'(secret_key[1]), 3);
    chk("t4_count", 1, 32'(attempt_count[1]), 4);
    chk("t4_exhausted", 1, 32'(key_exhausted[1]), 1);
    chk("t4_found", 1, 32'(key_found[1]), 0);

    // 5. non-owner write requests in SHUFFLE; shuf_complete is still high from the last key
    pulse_go(0);
    wait_start(1, 200, "t5_timeout");
    #1;
    pat_fixed = 1;
    init_wren = 1'b1;
    init_addr = 8'hAA;
    shuf_wren = 1'b0;
    shuf_addr = 8'h11;
    shuf_data = 8'h22;
    #1;
    chk("t5_addr", 0, 32'(mem_addr[0]), 32'h11);
    chk("t5_data", 0, 32'(mem_data[0]), 32'h22);
    chk("t5_wren", 0, 32'(mem_wren[0]), 0);
    @(posedge clk); #1 pat_fixed = 0;
    @(negedge clk);
    chk("t6_shuf_hold", 0, 32'({dec_start[0], busy[0]}), 32'b01);

    // 6. abort mid-DECRYPT
    wait_start(2, 200, "t6_timeout");
    repeat (5) @(negedge clk);
    @(posedge clk); #1 abort[0] = 1'b1;
    @(posedge clk); #1 abort[0] = 1'b0;
    @(negedge clk);
    chk("t6_busy", 0, 32'(busy[0]), 0);
    chk("t6_sub_stop", 0, 32'(sub_stop[0]), 1);
    chk("t6_wren", 0, 32'(mem_wren[0]), 0);
    chk("t6_flags", 0, 32'({key_found[0], key_exhausted[0]}), 0);
    @(negedge clk);
    chk("t6_sub_stop_end", 0, 32'(sub_stop[0]), 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
